// File: rtl/knn_pkg.sv
// knn_pkg: shared widths, FSM state encoding and distance helpers for the
// KNN distance engine.
// Build option: define KNN_SQ_DIST_EN to switch from Manhattan distance to
// saturated squared-Euclidean distance.
package knn_pkg;

    localparam int DIST_W  = 14;
    localparam int LABEL_W = 4;
    localparam int CH_W    = 8;
    localparam logic [DIST_W-1:0] SAT = 14'h3FFF;

`ifdef KNN_SQ_DIST_EN
    // Per-channel square is 16 bits; three of them sum to at most 195075.
    localparam int CHD_W = 2 * CH_W;
    localparam int SUM_W = 18;
`else
    // Per-channel |a-b| is 8 bits; three of them sum to at most 765.
    localparam int CHD_W = CH_W;
    localparam int SUM_W = 10;
`endif

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREFETCH = 3'd1,
        ST_RUN      = 3'd2,
        ST_END1     = 3'd3,
        ST_END2     = 3'd4,
        ST_DONE     = 3'd5
    } knn_state_e;

`ifdef KNN_SQ_DIST_EN
    function automatic logic [DIST_W-1:0] sat_dist(input logic [SUM_W-1:0] s);
        if (s > SUM_W'(SAT)) return SAT;
        return s[DIST_W-1:0];
    endfunction
`endif

endpackage

// File: rtl/knn_chan_dist.sv
// knn_chan_dist: distance contribution of one colour channel.
// Ports:
//   a, b : 8-bit channel values
//   d    : |a-b|, or (a-b)^2 when KNN_SQ_DIST_EN is defined
module knn_chan_dist
    import knn_pkg::*;
(
    input  logic [CH_W-1:0]  a,
    input  logic [CH_W-1:0]  b,
    output logic [CHD_W-1:0] d
);

    logic [CH_W-1:0] abs_diff;

    assign abs_diff = (a > b) ? (a - b) : (b - a);

`ifdef KNN_SQ_DIST_EN
    assign d = CHD_W'(abs_diff) * CHD_W'(abs_diff);
`else
    assign d = abs_diff;
`endif

endmodule

// File: rtl/knn_distance.sv
// knn_distance: streams a dictionary ROM group by group and emits, one beat
// per entry, the colour distance between each entry and a latched query pixel.
// Build option: KNN_SQ_DIST_EN selects saturated squared distance and adds one
// pipeline stage to all beat/marker outputs.
// Ports:
//   clk_en, reset_n        : rising-edge clock, async active-low reset
//   start, sample_rgb      : begin a classification with query {R,G,B}
//   dic_addr, dic_rd       : ROM read request (data returns one cycle later)
//   dic_data               : {label, R, G, B} from the ROM
//   dist_valid, distance, m: registered per-entry result beat
//   dic_end, dic_end_q     : two-cycle group-end marker
//   dic_go, knn_fin, busy  : run status
//
// state    | meaning
// IDLE     | waiting for start
// PREFETCH | covers the ROM latency of the first read
// RUN      | one distance beat per cycle for the current group
// END1     | first group-end cycle (dic_end)
// END2     | second group-end cycle (dic_end, dic_end_q)
// DONE     | all groups processed, knn_fin held until next start
module knn_distance
    import knn_pkg::*;
#(
    parameter int DIC_GROUPS = 16,
    parameter int GROUP_SIZE = 4
) (
    input  logic        clk_en,
    input  logic        reset_n,
    input  logic        start,
    input  logic [23:0] sample_rgb,
    output logic [5:0]  dic_addr,
    output logic        dic_rd,
    input  logic [27:0] dic_data,
    output logic        dic_go,
    output logic        dist_valid,
    output logic [13:0] distance,
    output logic [3:0]  m,
    output logic        dic_end,
    output logic        dic_end_q,
    output logic        knn_fin,
    output logic        busy
);

    localparam int K_W = (GROUP_SIZE > 1) ? $clog2(GROUP_SIZE) : 1;
    localparam int G_W = $clog2(DIC_GROUPS + 1);

    knn_state_e     state_q, state_d;
    logic [K_W-1:0] beat_q, beat_d;
    logic [G_W-1:0] grp_q, grp_d;
    logic [5:0]     rd_addr_q, rd_addr_d;
    logic [23:0]    sample_q, sample_d;
    logic           start_acc, last_beat, last_grp, load;
    logic           go_c, end_c, endq_c, done_c;

    assign start_acc = start & reset_n & ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign last_beat = (beat_q == K_W'(GROUP_SIZE - 1));
    assign last_grp  = (grp_q == G_W'(DIC_GROUPS - 1));

    always_ff @(posedge clk_en or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (start_acc) state_d = ST_PREFETCH;
            ST_PREFETCH:      state_d = ST_RUN;
            ST_RUN:           if (last_beat) state_d = ST_END1;
            ST_END1:          state_d = ST_END2;
            ST_END2:          state_d = last_grp ? ST_DONE : ST_RUN;
            default:          state_d = ST_IDLE;
        endcase
    end

    // Reads run two cycles ahead of the beat they feed: the first two entries
    // of each group are fetched in PREFETCH/IDLE or END1/END2, the rest while
    // earlier beats of the same group are still streaming.
    always_comb begin
        dic_rd = 1'b0;
        go_c   = 1'b0;
        end_c  = 1'b0;
        endq_c = 1'b0;
        done_c = 1'b0;
        busy   = 1'b1;
        case (state_q)
            ST_IDLE: begin
                busy   = 1'b0;
                dic_rd = start_acc;
            end
            ST_DONE: begin
                busy   = 1'b0;
                done_c = 1'b1;
                dic_rd = start_acc;
            end
            ST_PREFETCH: dic_rd = 1'b1;
            ST_RUN: begin
                go_c   = 1'b1;
                dic_rd = (int'(beat_q) + 2 < GROUP_SIZE);
            end
            ST_END1: begin
                go_c   = 1'b1;
                end_c  = 1'b1;
                dic_rd = !last_grp;
            end
            ST_END2: begin
                go_c   = 1'b1;
                end_c  = 1'b1;
                endq_c = 1'b1;
                dic_rd = !last_grp;
            end
            default: busy = 1'b0;
        endcase
    end

    assign dic_addr = start_acc ? 6'd0 : rd_addr_q;

    always_comb begin
        beat_d    = beat_q;
        grp_d     = grp_q;
        rd_addr_d = rd_addr_q;
        sample_d  = sample_q;
        if (start_acc) begin
            beat_d    = '0;
            grp_d     = '0;
            rd_addr_d = 6'd1;
            sample_d  = sample_rgb;
        end else begin
            if (dic_rd) rd_addr_d = rd_addr_q + 6'd1;
            if (state_q == ST_RUN) beat_d = last_beat ? '0 : beat_q + K_W'(1);
            if (state_q == ST_END2) grp_d = grp_q + G_W'(1);
        end
    end

    always_ff @(posedge clk_en or negedge reset_n) begin
        if (!reset_n) begin
            beat_q    <= '0;
            grp_q     <= '0;
            rd_addr_q <= '0;
            sample_q  <= '0;
        end else begin
            beat_q    <= beat_d;
            grp_q     <= grp_d;
            rd_addr_q <= rd_addr_d;
            sample_q  <= sample_d;
        end
    end

    // dic_data in the cycle before a RUN cycle always holds that beat's entry.
    assign load = (state_d == ST_RUN);

    logic [CHD_W-1:0] cd_r, cd_g, cd_b;

    knn_chan_dist u_dist_r (.a(dic_data[23:16]), .b(sample_q[23:16]), .d(cd_r));
    knn_chan_dist u_dist_g (.a(dic_data[15:8]),  .b(sample_q[15:8]),  .d(cd_g));
    knn_chan_dist u_dist_b (.a(dic_data[7:0]),   .b(sample_q[7:0]),   .d(cd_b));

    logic [SUM_W-1:0]   sum;
    logic [DIST_W-1:0]  dist_src;
    logic [LABEL_W-1:0] lbl_src;
    logic               vld_src;

`ifdef KNN_SQ_DIST_EN
    logic [CHD_W-1:0]   p1_r_q, p1_r_d, p1_g_q, p1_g_d, p1_b_q, p1_b_d;
    logic [LABEL_W-1:0] p1_lbl_q, p1_lbl_d;
    logic               p1_vld_q, p1_vld_d;
    logic [3:0]         ctl_q, ctl_d;

    always_comb begin
        p1_vld_d = load;
        p1_r_d   = load ? cd_r : p1_r_q;
        p1_g_d   = load ? cd_g : p1_g_q;
        p1_b_d   = load ? cd_b : p1_b_q;
        p1_lbl_d = load ? dic_data[27:24] : p1_lbl_q;
        // Markers are delayed by the extra stage so they stay beat-aligned.
        ctl_d    = {go_c, end_c, endq_c, done_c & ~start_acc};
    end

    always_ff @(posedge clk_en or negedge reset_n) begin
        if (!reset_n) begin
            p1_r_q   <= '0;
            p1_g_q   <= '0;
            p1_b_q   <= '0;
            p1_lbl_q <= '0;
            p1_vld_q <= 1'b0;
            ctl_q    <= '0;
        end else begin
            p1_r_q   <= p1_r_d;
            p1_g_q   <= p1_g_d;
            p1_b_q   <= p1_b_d;
            p1_lbl_q <= p1_lbl_d;
            p1_vld_q <= p1_vld_d;
            ctl_q    <= ctl_d;
        end
    end

    assign sum       = SUM_W'(p1_r_q) + SUM_W'(p1_g_q) + SUM_W'(p1_b_q);
    assign dist_src  = sat_dist(sum);
    assign lbl_src   = p1_lbl_q;
    assign vld_src   = p1_vld_q;
    assign dic_go    = ctl_q[3];
    assign dic_end   = ctl_q[2];
    assign dic_end_q = ctl_q[1];
    assign knn_fin   = ctl_q[0] & ~start_acc;
`else
    assign sum       = SUM_W'(cd_r) + SUM_W'(cd_g) + SUM_W'(cd_b);
    assign dist_src  = DIST_W'(sum);
    assign lbl_src   = dic_data[27:24];
    assign vld_src   = load;
    assign dic_go    = go_c;
    assign dic_end   = end_c;
    assign dic_end_q = endq_c;
    assign knn_fin   = done_c & ~start_acc;
`endif

    logic               dist_valid_q, dist_valid_d;
    logic [DIST_W-1:0]  distance_q, distance_d;
    logic [LABEL_W-1:0] m_q, m_d;

    always_comb begin
        dist_valid_d = vld_src;
        distance_d   = vld_src ? dist_src : distance_q;
        m_d          = vld_src ? lbl_src : m_q;
    end

    always_ff @(posedge clk_en or negedge reset_n) begin
        if (!reset_n) begin
            dist_valid_q <= 1'b0;
            distance_q   <= '0;
            m_q          <= '0;
        end else begin
            dist_valid_q <= dist_valid_d;
            distance_q   <= distance_d;
            m_q          <= m_d;
        end
    end

    assign dist_valid = dist_valid_q;
    assign distance   = distance_q;
    assign m          = m_q;

endmodule

// File: tb/tb_knn_distance.sv
// tb_knn_distance: directed bench for knn_distance with a registered ROM model.
module tb_knn_distance;

    localparam int NG = 16;
    localparam int GS = 4;
    localparam int BUDGET = 200;
`ifdef KNN_SQ_DIST_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif
    localparam int FIN_EXP = 2 + LAT + NG * (GS + 2);

    logic        clk_en = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0;
    logic [23:0] sample_rgb = '0;
    logic [5:0]  dic_addr;
    logic        dic_rd;
    logic [27:0] dic_data = '0;
    logic        dic_go, dist_valid, dic_end, dic_end_q, knn_fin, busy;
    logic [13:0] distance;
    logic [3:0]  m;

    logic [27:0] rom [0:63];
    int          checks = 0;
    int          errors = 0;
    int          fin_cyc, n_beats, n_pairs, n_ends, n_endq, n_rd, n_bad, n_act;
    logic        fin_at0;
    int          got_dist [0:63];
    logic [3:0]  got_m [0:63];

    knn_distance #(.DIC_GROUPS(NG), .GROUP_SIZE(GS)) dut (
        .clk_en     (clk_en),
        .reset_n    (reset_n),
        .start      (start),
        .sample_rgb (sample_rgb),
        .dic_addr   (dic_addr),
        .dic_rd     (dic_rd),
        .dic_data   (dic_data),
        .dic_go     (dic_go),
        .dist_valid (dist_valid),
        .distance   (distance),
        .m          (m),
        .dic_end    (dic_end),
        .dic_end_q  (dic_end_q),
        .knn_fin    (knn_fin),
        .busy       (busy)
    );

    always #5 clk_en = ~clk_en;

    always @(posedge clk_en) if (dic_rd) dic_data <= rom[dic_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_dist(input logic [27:0] e, input logic [23:0] s);
        int acc;
        int a;
        int b;
        int df;
        acc = 0;
        for (int c = 0; c < 3; c++) begin
            a = int'(e[c*8 +: 8]);
            b = int'(s[c*8 +: 8]);
            df = (a > b) ? a - b : b - a;
            acc += (LAT != 0) ? df * df : df;
        end
        if (acc > 16383) acc = 16383;
        return acc;
    endfunction

    task automatic fill_rom(input logic [27:0] v);
        for (int i = 0; i < 64; i++) rom[i] = v;
    endtask

    // Cycle k=0 is the cycle start is driven; every later cycle is sampled
    // on the falling edge.
    task automatic run_class(input logic [23:0] smp, input int pulse_at, input logic [23:0] smp2);
        logic prev_end;
        logic prev_endq;
        fin_cyc = -1;
        n_beats = 0;
        n_pairs = 0;
        n_ends  = 0;
        n_endq  = 0;
        n_bad   = 0;
        prev_end  = 1'b0;
        prev_endq = 1'b0;
        @(negedge clk_en);
        start = 1'b1;
        sample_rgb = smp;
        #1;
        fin_at0 = knn_fin;
        n_rd = dic_rd ? 1 : 0;
        for (int k = 1; k <= BUDGET; k++) begin
            @(negedge clk_en);
            if (dist_valid) begin
                if (n_beats < 64) begin
                    got_dist[n_beats] = int'(distance);
                    got_m[n_beats] = m;
                    if (distance !== 14'(exp_dist(rom[n_beats], smp))) n_bad++;
                    if (m !== rom[n_beats][27:24]) n_bad++;
                end
                if (k != 2 + LAT + (n_beats / GS) * (GS + 2) + (n_beats % GS)) n_bad++;
                if (dic_end) n_bad++;
                n_beats++;
            end
            if (dic_end) n_ends++;
            if (dic_end_q) begin
                n_endq++;
                if (!dic_end) n_bad++;
            end
            if (dic_end && dic_end_q && prev_end && !prev_endq) n_pairs++;
            if (dic_go !== ((k >= 2 + LAT) && !knn_fin)) n_bad++;
            if (dic_rd) n_rd++;
            prev_end  = dic_end;
            prev_endq = dic_end_q;
            start = (k == pulse_at);
            if (k == pulse_at) sample_rgb = smp2;
            if (knn_fin) begin
                fin_cyc = k;
                break;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        fill_rom({4'd3, 24'h808080});

        // Reset values
        #2 reset_n = 1'b0;
        repeat (2) @(negedge clk_en);
        chk("rst_addr", 32'(dic_addr), 0);
        chk("rst_rd", 32'(dic_rd), 0);
        chk("rst_go", 32'(dic_go), 0);
        chk("rst_valid", 32'(dist_valid), 0);
        chk("rst_dist", 32'(distance), 0);
        chk("rst_m", 32'(m), 0);
        chk("rst_end", 32'(dic_end), 0);
        chk("rst_endq", 32'(dic_end_q), 0);
        chk("rst_fin", 32'(knn_fin), 0);
        chk("rst_busy", 32'(busy), 0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk_en);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_rd", 32'(dic_rd), 0);

        // A: uniform dictionary equal to the sample
        run_class(24'h808080, -1, 24'h0);
        chk("A_fin_cycle", 32'(fin_cyc), 32'(FIN_EXP));
        chk("A_beats", 32'(n_beats), 64);
        chk("A_bad", 32'(n_bad), 0);
        chk("A_pairs", 32'(n_pairs), 16);
        chk("A_ends", 32'(n_ends), 32);
        chk("A_endq", 32'(n_endq), 16);
        chk("A_reads", 32'(n_rd), 64);
        chk("A_dist0", 32'(got_dist[0]), 0);
        chk("A_m63", 32'(got_m[63]), 3);
        chk("A_done_busy", 32'(busy), 0);
        @(negedge clk_en);
        chk("A_hold_valid", 32'(dist_valid), 0);
        chk("A_hold_dist", 32'(distance), 0);
        chk("A_hold_m", 32'(m), 3);
        chk("A_fin_level", 32'(knn_fin), 1);

        // B: black sample against hand-built entries, restarted from DONE
        fill_rom({4'd1, 24'h000000});
        rom[0]  = {4'hA, 24'h102030};
        rom[5]  = {4'd2, 24'hFFFFFF};
        rom[7]  = {4'd5, 24'h20E010};
        rom[63] = {4'hF, 24'h0A0000};
        run_class(24'h000000, -1, 24'h0);
        chk("B_fin_drop", 32'(fin_at0), 0);
        chk("B_fin_cycle", 32'(fin_cyc), 32'(FIN_EXP));
        chk("B_bad", 32'(n_bad), 0);
        chk("B_dist5", 32'(got_dist[5]), (LAT != 0) ? 16383 : 765);
        chk("B_m5", 32'(got_m[5]), 2);
        chk("B_dist0", 32'(got_dist[0]), (LAT != 0) ? 3584 : 96);
        chk("B_m0", 32'(got_m[0]), 10);
        chk("B_dist63", 32'(got_dist[63]), (LAT != 0) ? 100 : 10);

        // C: mixed sample
        run_class(24'h40C020, -1, 24'h0);
        chk("C_fin_cycle", 32'(fin_cyc), 32'(FIN_EXP));
        chk("C_bad", 32'(n_bad), 0);
        chk("C_dist7", 32'(got_dist[7]), (LAT != 0) ? 2304 : 80);
        chk("C_m7", 32'(got_m[7]), 5);
        chk("C_dist1", 32'(got_dist[1]), (LAT != 0) ? 16383 : 288);
        chk("C_dist5", 32'(got_dist[5]), (LAT != 0) ? 16383 : 477);

        // D: start pulse mid-run with a different sample must be ignored
        run_class(24'h000000, 10, 24'hFFFFFF);
        chk("D_fin_drop", 32'(fin_at0), 0);
        chk("D_fin_cycle", 32'(fin_cyc), 32'(FIN_EXP));
        chk("D_bad", 32'(n_bad), 0);
        chk("D_beats", 32'(n_beats), 64);
        chk("D_dist5", 32'(got_dist[5]), (LAT != 0) ? 16383 : 765);
        chk("D_reads", 32'(n_rd), 64);

        // E: reset asserted during END1 of group 7
        fill_rom({4'd3, 24'h808080});
        @(negedge clk_en);
        start = 1'b1;
        sample_rgb = 24'h000000;
        @(negedge clk_en);
        start = 1'b0;
        repeat (47 + LAT) @(negedge clk_en);
        chk("E_end1_end", 32'(dic_end), 1);
        chk("E_end1_endq", 32'(dic_end_q), 0);
        chk("E_end1_valid", 32'(dist_valid), 0);
        chk("E_pre_dist", 32'(distance), 32'(exp_dist({4'd3, 24'h808080}, 24'h000000)));
        reset_n = 1'b0;
        #1;
        chk("E_rst_addr", 32'(dic_addr), 0);
        chk("E_rst_rd", 32'(dic_rd), 0);
        chk("E_rst_go", 32'(dic_go), 0);
        chk("E_rst_valid", 32'(dist_valid), 0);
        chk("E_rst_dist", 32'(distance), 0);
        chk("E_rst_m", 32'(m), 0);
        chk("E_rst_end", 32'(dic_end), 0);
        chk("E_rst_endq", 32'(dic_end_q), 0);
        chk("E_rst_fin", 32'(knn_fin), 0);
        chk("E_rst_busy", 32'(busy), 0);
        repeat (2) @(negedge clk_en);
        reset_n = 1'b1;
        n_act = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_en);
            if (dic_rd || dic_go || dist_valid || dic_end || dic_end_q || knn_fin || busy) n_act++;
        end
        chk("E_quiet", 32'(n_act), 0);

        // F: fresh run after the abort
        run_class(24'h000000, -1, 24'h0);
        chk("F_fin_cycle", 32'(fin_cyc), 32'(FIN_EXP));
        chk("F_beats", 32'(n_beats), 64);
        chk("F_pairs", 32'(n_pairs), 16);
        chk("F_bad", 32'(n_bad), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
